alu_control_pipe: RTL and testbench

Pipelined, handshaked successor of the combinational ALU function decoder.
- Accepts {is_alu, opcode, func, tag} from the decode stage and emits the ALU function code plus side-band flags after a parametrised number of register stages.
- Provides valid/ready backpressure, bubble collapsing and a synchronous flush.
- Sits between instruction decode and the execute stage of the pipelined datapath.

---
 rtl/alu_control_pipe_if.sv | 45 ++++
 rtl/alu_control_pipe.sv | 178 +++++++++++++++++
 tb/tb_alu_control_pipe.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_control_pipe_if.sv
// ---------------------------------------------------------------------------
// alu_control_pipe_if
// Handshake bundle between the decode stage, the ALU control pipe and the
// execute stage.
//   in_valid/in_ready        : input handshake (decode -> pipe)
//   in_is_alu/in_opcode/
//   in_func/in_tag           : instruction fields offered with in_valid
//   out_valid/out_ready      : output handshake (pipe -> execute)
//   out_func_code/out_tag/
//   out_illegal/out_is_branch/
//   out_is_wwd               : decoded entry presented with out_valid
// Modports:
//   master : the environment (drives inputs and out_ready)
//   slave  : the pipe itself
// ---------------------------------------------------------------------------
interface alu_control_pipe_if #(
  parameter int TAG_W  = 4,
  parameter int FUNC_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic              in_is_alu;
  logic [3:0]        in_opcode;
  logic [5:0]        in_func;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [FUNC_W-1:0] out_func_code;
  logic [TAG_W-1:0]  out_tag;
  logic              out_illegal;
  logic              out_is_branch;
  logic              out_is_wwd;

  modport master (
    output in_valid, in_is_alu, in_opcode, in_func, in_tag, out_ready,
    input  in_ready, out_valid, out_func_code, out_tag,
           out_illegal, out_is_branch, out_is_wwd
  );

  modport slave (
    input  in_valid, in_is_alu, in_opcode, in_func, in_tag, out_ready,
    output in_ready, out_valid, out_func_code, out_tag,
           out_illegal, out_is_branch, out_is_wwd
  );
endinterface

// File: rtl/alu_control_pipe.sv
// ---------------------------------------------------------------------------
// alu_control_pipe
// Pipelined ALU function decoder with valid/ready flow control.
// The instruction is decoded combinationally at the input; the decoded code,
// tag and flags then travel through STAGES register stages. Bubbles collapse,
// a full pipe holds STAGES entries, flush kills everything in flight.
// Ports:
//   clk, reset (sync, active-high), flush (sync)
//   bus         : alu_control_pipe_if.slave (input and output handshakes)
//   illegal_cnt : saturating count of illegal entries handed to execute
//                 (only when ALU_CTRL_ILLEGAL_CNT_EN is defined)
// Optional feature macro: ALU_CTRL_ILLEGAL_CNT_EN
// Encodings:
//   opcodes : BNE=0 BEQ=1 BGZ=2 BLZ=3 ADI=4 ORI=5 LHI=6 LWD=7 SWD=8
//             JMP=9 JAL=10 (R-type uses in_is_alu)
//   func    : ADD=0 SUB=1 AND=2 ORR=3 NOT=4 TCP=5 SHL=6 SHR=7 WWD=28
//   ALU code: ADD=0 SUB=1 AND=2 OR=3 NOT=4 TCP=5 ALS=6 ARS=7 ZERO=15
// ---------------------------------------------------------------------------
module alu_control_pipe #(
  parameter int STAGES = 2,
  parameter int FUNC_W = 4,
  parameter int TAG_W  = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  alu_control_pipe_if.slave bus
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
  ,
  output logic [7:0] illegal_cnt
`endif
);

  localparam logic [3:0] OP_BNE = 4'd0;
  localparam logic [3:0] OP_BEQ = 4'd1;
  localparam logic [3:0] OP_ADI = 4'd4;
  localparam logic [3:0] OP_ORI = 4'd5;
  localparam logic [3:0] OP_LWD = 4'd7;
  localparam logic [3:0] OP_SWD = 4'd8;

  localparam logic [5:0] FN_ADD = 6'd0;
  localparam logic [5:0] FN_SUB = 6'd1;
  localparam logic [5:0] FN_AND = 6'd2;
  localparam logic [5:0] FN_ORR = 6'd3;
  localparam logic [5:0] FN_NOT = 6'd4;
  localparam logic [5:0] FN_TCP = 6'd5;
  localparam logic [5:0] FN_SHL = 6'd6;
  localparam logic [5:0] FN_SHR = 6'd7;
  localparam logic [5:0] FN_WWD = 6'd28;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_NOT  = 4'd4;
  localparam logic [3:0] ALU_TCP  = 4'd5;
  localparam logic [3:0] ALU_ALS  = 4'd6;
  localparam logic [3:0] ALU_ARS  = 4'd7;
  localparam logic [3:0] ALU_ZERO = 4'd15;

  localparam int LAST = STAGES - 1;

  typedef struct packed {
    logic [3:0]       code;
    logic [TAG_W-1:0] tag;
    logic             illegal;
    logic             branch;
    logic             wwd;
  } payload_t;

  localparam payload_t PAYLOAD_RESET = '{code: ALU_ZERO, tag: '0,
                                         illegal: 1'b0, branch: 1'b0, wwd: 1'b0};

  payload_t dec;
  logic     valid_reg [STAGES];
  payload_t data_reg  [STAGES];
  logic     src_valid [STAGES];
  payload_t src_data  [STAGES];
  logic     load      [STAGES];
  logic     room;

  // Input decode
  always_comb begin
    dec         = PAYLOAD_RESET;
    dec.tag     = bus.in_tag;
    if (bus.in_is_alu) begin
      case (bus.in_func)
        FN_ADD:  dec.code = ALU_ADD;
        FN_SUB:  dec.code = ALU_SUB;
        FN_AND:  dec.code = ALU_AND;
        FN_ORR:  dec.code = ALU_OR;
        FN_NOT:  dec.code = ALU_NOT;
        FN_TCP:  dec.code = ALU_TCP;
        FN_SHL:  dec.code = ALU_ALS;
        FN_SHR:  dec.code = ALU_ARS;
        FN_WWD: begin
          dec.code = ALU_ADD;
          dec.wwd  = 1'b1;
        end
        default: dec.illegal = 1'b1;
      endcase
    end else begin
      case (bus.in_opcode)
        OP_ADI, OP_LWD, OP_SWD: dec.code = ALU_ADD;
        OP_ORI:                 dec.code = ALU_OR;
        OP_BNE, OP_BEQ: begin
          dec.code   = ALU_SUB;
          dec.branch = 1'b1;
        end
        default:                dec.code = ALU_ZERO;
      endcase
    end
  end

  // Stage k may load when it or any stage after it is empty, or when the
  // output is being consumed: that is exactly "empty or being freed".
  always_comb begin
    room = bus.out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      room    = room || !valid_reg[k];
      load[k] = room;
    end
  end

  // Per-stage source selection: stage 0 takes the decoder, others the
  // previous stage.
  for (genvar gi = 0; gi < STAGES; gi++) begin : g_src
    if (gi == 0) begin : g_head
      assign src_valid[gi] = bus.in_valid;
      assign src_data[gi]  = dec;
    end else begin : g_body
      assign src_valid[gi] = valid_reg[gi-1];
      assign src_data[gi]  = data_reg[gi-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_reg[k] <= 1'b0;
        data_reg[k]  <= PAYLOAD_RESET;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (flush)        valid_reg[k] <= 1'b0;
        else if (load[k]) valid_reg[k] <= src_valid[k];
        if (load[k])      data_reg[k]  <= src_data[k];
      end
    end
  end

  // Flush accepts (and discards) whatever is offered, so in_ready is forced.
  assign bus.in_ready      = load[0] || flush;
  assign bus.out_valid     = valid_reg[LAST];
  // Payload is masked so idle outputs always read as reset values.
  assign bus.out_func_code = valid_reg[LAST] ? FUNC_W'(data_reg[LAST].code)
                                             : FUNC_W'(ALU_ZERO);
  assign bus.out_tag       = valid_reg[LAST] ? data_reg[LAST].tag : '0;
  assign bus.out_illegal   = valid_reg[LAST] && data_reg[LAST].illegal;
  assign bus.out_is_branch = valid_reg[LAST] && data_reg[LAST].branch;
  assign bus.out_is_wwd    = valid_reg[LAST] && data_reg[LAST].wwd;

`ifdef ALU_CTRL_ILLEGAL_CNT_EN
  logic [7:0] illegal_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_cnt_reg <= 8'd0;
    end else if (bus.out_valid && bus.out_ready && bus.out_illegal &&
                 illegal_cnt_reg != 8'hFF) begin
      illegal_cnt_reg <= illegal_cnt_reg + 8'd1;
    end
  end

  assign illegal_cnt = illegal_cnt_reg;
`endif

endmodule

// File: tb/tb_alu_control_pipe.sv
// ---------------------------------------------------------------------------
// tb_alu_control_pipe
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic. A queue model of the pipe (entries with the earliest
// cycle they may show at the output) is compared with the DUT every cycle.
// ---------------------------------------------------------------------------
module tb_alu_control_pipe;
  localparam int STAGES = 2;
  localparam int FUNC_W = 4;
  localparam int TAG_W  = 4;

  localparam int OP_BNE = 0, OP_BEQ = 1, OP_ADI = 4, OP_ORI = 5, OP_LWD = 7, OP_SWD = 8;
  localparam int FN_ADD = 0, FN_SUB = 1, FN_AND = 2, FN_ORR = 3, FN_NOT = 4;
  localparam int FN_TCP = 5, FN_SHL = 6, FN_SHR = 7, FN_WWD = 28;
  localparam int C_ADD = 0, C_SUB = 1, C_AND = 2, C_OR = 3, C_NOT = 4;
  localparam int C_TCP = 5, C_ALS = 6, C_ARS = 7, C_ZERO = 15;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  always #5 clk = ~clk;

  alu_control_pipe_if #(.TAG_W(TAG_W), .FUNC_W(FUNC_W)) bus ();

`ifdef ALU_CTRL_ILLEGAL_CNT_EN
  logic [7:0] illegal_cnt;
`endif

  alu_control_pipe #(.STAGES(STAGES), .FUNC_W(FUNC_W), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
    ,
    .illegal_cnt (illegal_cnt)
`endif
  );

  typedef struct {
    int code;
    int tag;
    int ill;
    int br;
    int wwd;
    int avail;
  } ent_t;

  ent_t q[$];
  int   out_log[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   cnt_exp = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic ent_t decode(input int alu, input int op, input int fn, input int tag);
    ent_t e;
    e.code = C_ZERO; e.tag = tag; e.ill = 0; e.br = 0; e.wwd = 0; e.avail = 0;
    if (alu != 0) begin
      case (fn)
        FN_ADD: e.code = C_ADD;
        FN_SUB: e.code = C_SUB;
        FN_AND: e.code = C_AND;
        FN_ORR: e.code = C_OR;
        FN_NOT: e.code = C_NOT;
        FN_TCP: e.code = C_TCP;
        FN_SHL: e.code = C_ALS;
        FN_SHR: e.code = C_ARS;
        FN_WWD: begin e.code = C_ADD; e.wwd = 1; end
        default: e.ill = 1;
      endcase
    end else begin
      case (op)
        OP_ADI, OP_LWD, OP_SWD: e.code = C_ADD;
        OP_ORI: e.code = C_OR;
        OP_BNE, OP_BEQ: begin e.code = C_SUB; e.br = 1; end
        default: e.code = C_ZERO;
      endcase
    end
    return e;
  endfunction

  task automatic set_in(input bit v, input bit alu, input int op, input int fn, input int tag);
    bus.in_valid  = v;
    bus.in_is_alu = alu;
    bus.in_opcode = 4'(op);
    bus.in_func   = 6'(fn);
    bus.in_tag    = TAG_W'(tag);
  endtask

  // One clock: compare at negedge+1, advance the model, step to next negedge.
  task automatic cycle(output bit acc);
    bit   ov, ir, leave;
    ent_t e;
    #1;
    ov = (q.size() > 0) && (q[0].avail <= cyc);
    ir = flush || (q.size() < STAGES) || bus.out_ready;
    check("in_ready", int'(bus.in_ready), int'(ir));
    check("out_valid", int'(bus.out_valid), int'(ov));
    if (ov) begin
      check("out_func_code", int'(bus.out_func_code), q[0].code);
      check("out_tag", int'(bus.out_tag), q[0].tag);
      check("out_illegal", int'(bus.out_illegal), q[0].ill);
      check("out_is_branch", int'(bus.out_is_branch), q[0].br);
      check("out_is_wwd", int'(bus.out_is_wwd), q[0].wwd);
    end else begin
      check("idle_func_code", int'(bus.out_func_code), C_ZERO);
      check("idle_tag", int'(bus.out_tag), 0);
      check("idle_flags", int'({bus.out_illegal, bus.out_is_branch, bus.out_is_wwd}), 0);
    end
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
    check("illegal_cnt", int'(illegal_cnt), cnt_exp);
`endif
    acc = bus.in_valid && ir;
    if (reset) begin
      q.delete();
      cnt_exp = 0;
      acc = 1'b0;
    end else begin
      leave = ov && bus.out_ready;
      if (leave) begin
        out_log.push_back(q[0].tag);
        if (q[0].ill != 0 && cnt_exp < 255) cnt_exp++;
        void'(q.pop_front());
      end
      if (flush) begin
        q.delete();
      end else if (acc) begin
        e = decode(int'(bus.in_is_alu), int'(bus.in_opcode), int'(bus.in_func), int'(bus.in_tag));
        e.avail = cyc + STAGES;
        q.push_back(e);
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  int legal_fn [9] = '{FN_ADD, FN_SUB, FN_AND, FN_ORR, FN_NOT, FN_TCP, FN_SHL, FN_SHR, FN_WWD};

  initial begin
    bit acc;
    int t, accepted;
    int fn;
    reset = 1'b1;
    flush = 1'b0;
    bus.out_ready = 1'b1;
    set_in(1'b0, 1'b0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_func_code", int'(bus.out_func_code), 15);
    check("rst_tag", int'(bus.out_tag), 0);

    // Single SUB entry, latency STAGES
    set_in(1'b1, 1'b1, 0, FN_SUB, 3);
    cycle(acc);
    set_in(1'b0, 1'b0, 0, 0, 0);
    check("sub_early_valid", int'(bus.out_valid), 0);
    cycle(acc);
    check("sub_valid", int'(bus.out_valid), 1);
    check("sub_code", int'(bus.out_func_code), 1);
    check("sub_tag", int'(bus.out_tag), 3);
    check("sub_flags", int'({bus.out_illegal, bus.out_is_branch, bus.out_is_wwd}), 0);
    cycle(acc);

    // Back-to-back ADI / ORI / BEQ
    set_in(1'b1, 1'b0, OP_ADI, 0, 1);
    cycle(acc);
    set_in(1'b1, 1'b0, OP_ORI, 0, 2);
    cycle(acc);
    check("b2b_tag1", int'(bus.out_tag), 1);
    check("b2b_code1", int'(bus.out_func_code), 0);
    set_in(1'b1, 1'b0, OP_BEQ, 0, 3);
    cycle(acc);
    check("b2b_tag2", int'(bus.out_tag), 2);
    check("b2b_code2", int'(bus.out_func_code), 3);
    check("b2b_br2", int'(bus.out_is_branch), 0);
    set_in(1'b0, 1'b0, 0, 0, 0);
    cycle(acc);
    check("b2b_tag3", int'(bus.out_tag), 3);
    check("b2b_code3", int'(bus.out_func_code), 1);
    check("b2b_br3", int'(bus.out_is_branch), 1);
    cycle(acc);

    // Backpressure: source holds an entry until it is accepted
    out_log.delete();
    bus.out_ready = 1'b0;
    t = 4;
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      set_in(1'b1, 1'b0, OP_ADI, 0, t);
      cycle(acc);
      if (acc) begin accepted++; t++; end
    end
    check("bp_accepted", accepted, 2);
    check("bp_in_ready", int'(bus.in_ready), 0);
    check("bp_hold_tag", int'(bus.out_tag), 4);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && t <= 9; i++) begin
      set_in(1'b1, 1'b0, OP_ADI, 0, t);
      cycle(acc);
      if (acc) t++;
    end
    set_in(1'b0, 1'b0, 0, 0, 0);
    repeat (4) cycle(acc);
    check("bp_drain_count", out_log.size(), 6);
    for (int i = 0; i < out_log.size() && i < 6; i++) check("bp_order", out_log[i], 4 + i);

    // Illegal R-type func
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
    check("cnt_before", int'(illegal_cnt), 0);
`endif
    set_in(1'b1, 1'b1, 0, 6'h3F, 7);
    cycle(acc);
    set_in(1'b0, 1'b0, 0, 0, 0);
    cycle(acc);
    check("ill_code", int'(bus.out_func_code), 15);
    check("ill_flag", int'(bus.out_illegal), 1);
    check("ill_tag", int'(bus.out_tag), 7);
    cycle(acc);
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
    check("cnt_after", int'(illegal_cnt), 1);
`endif
    cycle(acc);

    // Flush with two held entries plus a new input
    out_log.delete();
    bus.out_ready = 1'b0;
    set_in(1'b1, 1'b0, OP_ADI, 0, 10);
    cycle(acc);
    set_in(1'b1, 1'b0, OP_ADI, 0, 11);
    cycle(acc);
    set_in(1'b1, 1'b0, OP_ADI, 0, 12);
    flush = 1'b1;
    #1;
    check("flush_in_ready", int'(bus.in_ready), 1);
    cycle(acc);
    flush = 1'b0;
    set_in(1'b0, 1'b0, 0, 0, 0);
    check("flush_out_valid", int'(bus.out_valid), 0);
    bus.out_ready = 1'b1;
    repeat (4) cycle(acc);
    check("flush_no_leak", out_log.size(), 0);

    // Reset while full
    bus.out_ready = 1'b0;
    set_in(1'b1, 1'b0, OP_ORI, 0, 13);
    cycle(acc);
    set_in(1'b1, 1'b0, OP_ORI, 0, 14);
    cycle(acc);
    set_in(1'b1, 1'b0, OP_ORI, 0, 15);
    reset = 1'b1;
    cycle(acc);
    reset = 1'b0;
    set_in(1'b0, 1'b0, 0, 0, 0);
    check("rst2_out_valid", int'(bus.out_valid), 0);
    check("rst2_func_code", int'(bus.out_func_code), 15);
    check("rst2_tag", int'(bus.out_tag), 0);
    bus.out_ready = 1'b1;
    set_in(1'b1, 1'b1, 0, FN_SHL, 1);
    cycle(acc);
    set_in(1'b0, 1'b0, 0, 0, 0);
    check("rst2_lat_early", int'(bus.out_valid), 0);
    cycle(acc);
    check("rst2_lat_valid", int'(bus.out_valid), 1);
    check("rst2_lat_tag", int'(bus.out_tag), 1);
    check("rst2_lat_code", int'(bus.out_func_code), 6);
    cycle(acc);

    // Randomized traffic
    acc = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (!bus.in_valid || acc) begin
        fn = ($urandom_range(0, 3) != 0) ? legal_fn[$urandom_range(0, 8)] : int'($urandom_range(0, 63));
        set_in($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
               int'($urandom_range(0, 15)), fn, int'($urandom_range(0, 15)));
      end
      if (((i / 200) % 2) == 1) bus.out_ready = ($urandom_range(0, 3) == 0);
      else                      bus.out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 49) == 0);
      reset = ($urandom_range(0, 199) == 0);
      cycle(acc);
    end
    reset = 1'b0;
    flush = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
